// File: rtl/filter_seq_pkg.sv
// Shared constants and FSM state type for the time-multiplexed EWMA filter.
package filter_seq_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned MUL_CYCLES = WIDTH;
    localparam int unsigned LAT        = 2 * WIDTH + 2;

    typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, SUM} state_t;

endpackage

// File: rtl/serial_mult.sv
// Radix-2 shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module serial_mult
    import filter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = filter_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_in;
    logic [WIDTH-1:0]   mcand_q, mcand;
    logic [WIDTH:0]     hi_sum;
    logic [CW-1:0]      cnt_q, cnt_d, step;
    logic               run_q, run_d;

    // The start cycle already performs the first step using the live operands,
    // so the product is complete at the edge ending the WIDTH-th cycle.
    always_comb begin
        mcand  = start ? op_a : mcand_q;
        acc_in = start ? {{WIDTH{1'b0}}, op_b} : acc_q;
        hi_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, mcand} : '0);
        step   = start ? CW'(1) : cnt_q + CW'(1);
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done   = 1'b0;
        if (start || run_q) begin
            acc_d = {hi_sum, acc_in[WIDTH-1:1]};
            cnt_d = step;
            done  = (step == CW'(WIDTH));
            run_d = !done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    assign prod_hi = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/filter_seq.sv
// Single-pole IIR y = a*y_prev + b*x with one shared serial multiplier, coefficient
// config handshake and sticky overrun flag.
module filter_seq
    import filter_seq_pkg::*;
#(
    parameter int unsigned       WIDTH = filter_seq_pkg::WIDTH,
    parameter logic [WIDTH-1:0]  RST_A = '0,
    parameter logic [WIDTH-1:0]  RST_B = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_strobe,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_a,
    input  logic [WIDTH-1:0] cfg_b,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    state_t           state_q, state_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] coef_a_q, coef_b_q, a_lat_q, b_lat_q, x_q, y_prev_q, pa_q;
    logic [WIDTH-1:0] dout_q, op_a, op_b, prod_hi, sat;
    logic [WIDTH:0]   sum;
    logic             dout_valid_q, overrun_q, mult_done;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: if (sample_strobe) begin
                state_d = MUL_A;
                start_d = 1'b1;
            end
            MUL_A: if (mult_done) begin
                state_d = MUL_B;
                start_d = 1'b1;
            end
            MUL_B:   if (mult_done) state_d = SUM;
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_a = (state_q == MUL_A) ? a_lat_q : b_lat_q;
        op_b = (state_q == MUL_A) ? y_prev_q : x_q;
        sum  = {1'b0, pa_q} + {1'b0, prod_hi};
        sat  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end

    assign cfg_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            coef_a_q     <= RST_A;
            coef_b_q     <= RST_B;
            a_lat_q      <= '0;
            b_lat_q      <= '0;
            x_q          <= '0;
            y_prev_q     <= '0;
            pa_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            dout_valid_q <= (state_q == SUM);
            if (state_q == IDLE && sample_strobe) begin
                a_lat_q <= coef_a_q;
                b_lat_q <= coef_b_q;
                x_q     <= din;
            end
            if (cfg_valid && cfg_ready) begin
                coef_a_q <= cfg_a;
                coef_b_q <= cfg_b;
            end
            // a*y_prev is still in the accumulator during the first MUL_B cycle.
            if (state_q == MUL_B && start_q) pa_q <= prod_hi;
            if (state_q == SUM) begin
                dout_q   <= sat;
                y_prev_q <= sat;
            end
            if (sample_strobe && state_q != IDLE) overrun_q <= 1'b1;
            else if (overrun_clr)                 overrun_q <= 1'b0;
        end
    end

    serial_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (start_q),
        .op_a    (op_a),
        .op_b    (op_b),
        .done    (mult_done),
        .prod_hi (prod_hi)
    );

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_filter_seq.sv
// Directed bench for filter_seq: reference EWMA model feeding an expected-result queue.
module tb_filter_seq;
    import filter_seq_pkg::*;

    localparam int unsigned W = WIDTH;

    logic         clk = 1'b0;
    logic         rst, sample_strobe, cfg_valid, overrun_clr;
    logic [W-1:0] din, cfg_a, cfg_b, dout;
    logic         dout_valid, cfg_ready, busy, overrun;

    int unsigned  n_pass  = 0;
    int unsigned  n_total = 0;
    int unsigned  valid_cnt = 0;
    logic [W-1:0] m_a, m_b, m_y;
    logic [W-1:0] exp_q[$];

    filter_seq u_dut (
        .clk           (clk),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .din           (din),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_a         (cfg_a),
        .cfg_b         (cfg_b),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dout_valid) valid_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] pa, pb;
        logic [W:0]     s;
        pa = {{W{1'b0}}, a} * {{W{1'b0}}, y};
        pb = {{W{1'b0}}, b} * {{W{1'b0}}, x};
        s  = {1'b0, pa[2*W-1:W]} + {1'b0, pb[2*W-1:W]};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_a = 16'h0000;
        m_b = 16'hFFFF;
        m_y = '0;
        exp_q.delete();
    endtask

    // Called at cycle 0 of a sample; returns in cycle 1.
    task automatic strobe_sample(input logic [W-1:0] x);
        logic [W-1:0] e;
        sample_strobe = 1'b1;
        din = x;
        e = model(m_a, m_b, x, m_y);
        m_y = e;
        exp_q.push_back(e);
        tick();
        sample_strobe = 1'b0;
        din = W'($urandom);
    endtask

    // Waits for dout_valid (bounded) and compares latency and value against the queue head.
    task automatic await_result(input string tag, input int unsigned from_cyc);
        int unsigned  cyc;
        logic [W-1:0] e;
        cyc = from_cyc;
        while (!dout_valid && cyc < LAT + 8) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, LAT);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, " dout"}, {dout_valid, dout}, {1'b1, e});
    endtask

    initial begin
        int unsigned cyc, vc;
        rst = 1'b1; sample_strobe = 1'b0; cfg_valid = 1'b0; overrun_clr = 1'b0;
        din = '0; cfg_a = '0; cfg_b = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check("rst dout", dout, 0);
        check("rst dout_valid", dout_valid, 0);
        check("rst busy", busy, 0);
        check("rst overrun", overrun, 0);
        check("rst cfg_ready", cfg_ready, 1);

        // Reset coefficients a=0, b=all-ones.
        strobe_sample(16'h1000);
        check("busy after strobe", busy, 1);
        await_result("rst coefs", 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();

        cfg_valid = 1'b1; cfg_a = 16'h8000; cfg_b = 16'h8000;
        check("cfg_ready idle", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        m_a = 16'h8000; m_b = 16'h8000;

        strobe_sample(16'h1000);
        await_result("half x", 1);
        check("first half value", dout, 16'h0800);
        // Back-to-back: strobe in the dout_valid cycle.
        strobe_sample(16'h1000);
        check("valid one cycle", dout_valid, 0);
        check("dout held", dout, 16'h0800);
        await_result("feedback", 1);
        check("feedback value", dout, 16'h0C00);

        // Dropped strobes while busy.
        strobe_sample(16'h2000);
        repeat (9) tick();
        sample_strobe = 1'b1; din = 16'hABCD;
        tick();
        sample_strobe = 1'b0;
        check("overrun set", overrun, 1);
        vc = valid_cnt;
        repeat (9) tick();
        sample_strobe = 1'b1; overrun_clr = 1'b1;
        tick();
        sample_strobe = 1'b0; overrun_clr = 1'b0;
        check("overrun set beats clr", overrun, 1);
        await_result("in-flight unaffected", 21);
        tick();
        tick();
        check("no extra valid", valid_cnt, vc + 1);
        check("overrun sticky", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun cleared", overrun, 0);

        // Config stalls while busy, old coefficients apply to the current sample.
        strobe_sample(16'h3000);
        repeat (4) tick();
        cfg_valid = 1'b1; cfg_a = 16'h4000; cfg_b = 16'hC000;
        #1;
        check("cfg_ready busy", cfg_ready, 0);
        cyc = 5;
        while (!cfg_ready && cyc < LAT + 8) begin
            tick();
            cyc++;
        end
        check("cfg_ready returns", cyc, LAT);
        await_result("old coefs", cyc);
        tick();
        cfg_valid = 1'b0;
        m_a = 16'h4000; m_b = 16'hC000;

        // Strobe and config in the same cycle.
        cfg_valid = 1'b1; cfg_a = 16'hFFFF; cfg_b = 16'hFFFF;
        strobe_sample(16'h5000);
        cfg_valid = 1'b0;
        m_a = 16'hFFFF; m_b = 16'hFFFF;
        await_result("new coefs", 1);

        for (int i = 0; i < 3; i++) begin
            tick();
            strobe_sample(16'hFFFF);
            await_result("saturate", 1);
        end
        check("saturated", dout, 16'hFFFF);

        // Reset mid-sample.
        tick();
        strobe_sample(16'h1234);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("midrst dout", dout, 0);
        check("midrst busy", busy, 0);
        check("midrst dout_valid", dout_valid, 0);
        vc = valid_cnt;
        repeat (40) tick();
        check("midrst no valid", valid_cnt, vc);
        strobe_sample(16'h1234);
        await_result("after rst", 1);
        check("after rst value", dout, 16'h1233);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
